multicycle_control_unit: RTL and testbench

Multicycle successor to the single-cycle processor controller: a state machine sequences each instruction over 3–5 cycles through one shared memory port and one ALU. It holds the condition flags in registers, evaluates the condition field once per instruction, and gates all architectural writes with that result. It adds a memory-ready stall handshake and branch-with-link. It sits between the instruction register and the multicycle datapath muxes and enables.

---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 148 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields and ALU flags in, datapath controls out
// master: drives cond/op/funct/rd/alu_flags/mem_ready, receives the datapath controls
// slave: the control unit side
interface multicycle_control_unit_if #(parameter int ALU_CTRL_W = 4);
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic mem_ready;
  logic pc_write;
  logic ir_write;
  logic adr_src;
  logic mem_write;
  logic reg_write;
  logic link_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0] reg_src;
  logic [1:0] imm_src;
  modport master (
    output cond, op, funct, rd, alu_flags, mem_ready,
    input pc_write, ir_write, adr_src, mem_write, reg_write, link_write,
    input result_src, alu_src_a, alu_src_b, alu_control, reg_src, imm_src
  );
  modport slave (
    input cond, op, funct, rd, alu_flags, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write, link_write,
    output result_src, alu_src_a, alu_src_b, alu_control, reg_src, imm_src
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing fetch/decode/execute over a shared memory port and ALU
// clk, rst (async, active-high); bus: slave side of multicycle_control_unit_if
module multicycle_control_unit #(
  parameter bit HAS_MEM_READY = 1'b1,
  parameter int ALU_CTRL_W = 4
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.slave bus
);
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMWRITE, MEMREAD, MEMWB, EXECR, EXECI, ALUWB, BRANCH} state_t;
  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic cond_ex_q, cond_ex_d;
  logic ready, cond_ok, is_cmp, arith;
  logic [3:0] cmd, dp_op, alu_op;
  logic [1:0] flag_w, result_src, alu_src_a, alu_src_b;
  logic pc_w, ir_w, adr_src, mem_w, reg_w, link_w;
  assign ready = HAS_MEM_READY ? bus.mem_ready : 1'b1;
  assign cmd = bus.funct[4:1];
  assign is_cmp = cmd == 4'b1010;
  assign arith = cmd == 4'b0100 || cmd == 4'b0010 || is_cmp;
  assign flag_w = {bus.funct[0], bus.funct[0] & arith};
  // CMP runs as SUB; unknown commands fall back to ADD
  assign dp_op = cmd == 4'b0010 || is_cmp ? 4'h1 :
                 cmd == 4'b0000 ? 4'h2 :
                 cmd == 4'b1100 ? 4'h3 :
                 cmd == 4'b0001 ? 4'h4 :
                 cmd == 4'b1101 ? 4'h5 : 4'h0;
  always_comb begin
    case (bus.cond)
      4'h0: cond_ok = flags_q[2];
      4'h1: cond_ok = ~flags_q[2];
      4'h2: cond_ok = flags_q[1];
      4'h3: cond_ok = ~flags_q[1];
      4'h4: cond_ok = flags_q[3];
      4'h5: cond_ok = ~flags_q[3];
      4'h6: cond_ok = flags_q[0];
      4'h7: cond_ok = ~flags_q[0];
      4'h8: cond_ok = flags_q[1] & ~flags_q[2];
      4'h9: cond_ok = ~flags_q[1] | flags_q[2];
      4'ha: cond_ok = flags_q[3] == flags_q[0];
      4'hb: cond_ok = flags_q[3] != flags_q[0];
      4'hc: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hd: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
      default: cond_ok = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      flags_q <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cond_ex_d = cond_ex_q;
    pc_w = 1'b0;
    ir_w = 1'b0;
    adr_src = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    link_w = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 4'h0;
    case (state_q)
      FETCH: begin
        result_src = 2'b10;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        ir_w = ready;
        pc_w = ready;
        state_d = ready ? DECODE : FETCH;
      end
      DECODE: begin
        result_src = 2'b10;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        cond_ex_d = cond_ok;
        state_d = bus.op == 2'b01 ? MEMADR :
                  bus.op == 2'b00 ? (bus.funct[5] ? EXECI : EXECR) :
                  bus.op == 2'b10 ? BRANCH : FETCH;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        alu_op = bus.funct[3] ? 4'h0 : 4'h1;
        state_d = bus.funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = cond_ex_q;
        state_d = FETCH;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w = cond_ex_q;
        pc_w = reg_w & (bus.rd == 4'hf);
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_b = state_q == EXECI ? 2'b01 : 2'b00;
        alu_op = dp_op;
        // flags commit at the EXEC exit edge, so only later instructions see them
        if (cond_ex_q)
          flags_d = {flag_w[1] ? bus.alu_flags[3:2] : flags_q[3:2], flag_w[0] ? bus.alu_flags[1:0] : flags_q[1:0]};
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w = cond_ex_q & ~is_cmp;
        pc_w = reg_w & (bus.rd == 4'hf);
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b = 2'b01;
        result_src = 2'b10;
        pc_w = cond_ex_q;
        link_w = cond_ex_q & bus.funct[4];
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  // write enables gated by rst so an abort cannot leak a write during reset
  assign bus.pc_write = pc_w & ~rst;
  assign bus.ir_write = ir_w & ~rst;
  assign bus.mem_write = mem_w & ~rst;
  assign bus.reg_write = reg_w & ~rst;
  assign bus.link_write = link_w & ~rst;
  assign bus.adr_src = adr_src;
  assign bus.result_src = result_src;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_control = ALU_CTRL_W'(alu_op);
  assign bus.reg_src = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.imm_src = bus.op;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and random instructions checked against a per-instruction cycle model
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus();
  multicycle_control_unit #(.HAS_MEM_READY(1'b1), .ALU_CTRL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  logic [3:0] mflags;
  logic [3:0] last_af;
  function automatic logic [19:0] mk(bit pcw, bit irw, bit adr, bit mw, bit rw, bit lw,
                                     bit [1:0] res, bit [1:0] sa, bit [1:0] sb, bit [3:0] alu);
    return {pcw, irw, adr, mw, rw, lw, res, sa, sb, alu, bus.op == 2'b01, bus.op == 2'b10, bus.op};
  endfunction
  function automatic logic [19:0] obs();
    return {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write, bus.reg_write, bus.link_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.reg_src, bus.imm_src};
  endfunction
  function automatic logic cond_true(logic [3:0] c, logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cy && !z;
      4'd9: return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic [3:0] dp_alu(logic [3:0] cmd);
    case (cmd)
      4'b0100: return 4'd0;
      4'b0010: return 4'd1;
      4'b1010: return 4'd1;
      4'b0000: return 4'd2;
      4'b1100: return 4'd3;
      4'b0001: return 4'd4;
      4'b1101: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction
  task automatic check(string tag, logic [19:0] e);
    checks++;
    assert (obs() === e) passed++;
    else $error("FAIL %s got=%h want=%h", tag, obs(), e);
  endtask
  task automatic step(string tag, logic [19:0] e, logic rdy, int af);
    bus.mem_ready = rdy;
    last_af = af < 0 ? 4'($urandom) : 4'(af);
    bus.alu_flags = last_af;
    @(negedge clk);
    check(tag, e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                     input int sf, input int sm, input int af);
    logic ok, w;
    logic [3:0] cmd;
    bus.cond = c;
    bus.op = o;
    bus.funct = f;
    bus.rd = r;
    cmd = f[4:1];
    ok = cond_true(c, mflags);
    repeat (sf) step("fetch_stall", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b0, -1);
    step("fetch", mk(1, 1, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b1, -1);
    step("decode", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'($urandom), -1);
    case (o)
      2'b10: step("branch", mk(ok, 0, 0, 0, 0, ok && f[4], 2'd2, 2'd0, 2'd1, 4'd0), 1'($urandom), -1);
      2'b01: begin
        step("memadr", mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, f[3] ? 4'd0 : 4'd1), 1'($urandom), -1);
        if (f[0]) begin
          repeat (sm) step("memread_stall", mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0), 1'b0, -1);
          step("memread", mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0), 1'b1, -1);
          step("memwb", mk(ok && r == 4'd15, 0, 0, 0, ok, 0, 2'd1, 2'd0, 2'd0, 4'd0), 1'($urandom), -1);
        end else
          step("memwrite", mk(0, 0, 1, ok, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0), 1'($urandom), -1);
      end
      2'b00: begin
        step("exec", mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, f[5] ? 2'd1 : 2'd0, dp_alu(cmd)), 1'($urandom), af);
        if (ok && f[0]) begin
          mflags[3:2] = last_af[3:2];
          if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mflags[1:0] = last_af[1:0];
        end
        w = ok && cmd != 4'b1010;
        step("aluwb", mk(w && r == 4'd15, 0, 0, 0, w, 0, 2'd0, 2'd0, 2'd0, 4'd0), 1'($urandom), -1);
      end
      default: ;
    endcase
  endtask
  initial begin
    mflags = 4'h0;
    bus.cond = 4'he;
    bus.op = 2'b00;
    bus.funct = 6'd0;
    bus.rd = 4'd0;
    bus.alu_flags = 4'h0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("reset_hold", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(4'he, 2'b00, 6'b001000, 4'd1, 0, 0, -1);
    run(4'he, 2'b00, 6'b000101, 4'd2, 0, 0, 4'b0100);
    run(4'h1, 2'b10, 6'b000000, 4'd0, 1, 0, -1);
    run(4'he, 2'b01, 6'b011001, 4'd15, 0, 2, -1);
    run(4'he, 2'b00, 6'b010101, 4'd3, 1, 0, 4'b0000);
    run(4'h0, 2'b01, 6'b011000, 4'd4, 0, 0, -1);
    run(4'he, 2'b10, 6'b010000, 4'd0, 0, 0, -1);
    run(4'he, 2'b00, 6'b101001, 4'd5, 0, 0, 4'hf);
    bus.cond = 4'he;
    bus.op = 2'b01;
    bus.funct = 6'b011001;
    bus.rd = 4'd15;
    step("fetch", mk(1, 1, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b1, -1);
    step("decode", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b1, -1);
    step("memadr", mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0), 1'b1, -1);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memread_pre_rst", mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0));
    rst = 1'b1;
    #1;
    check("rst_async_memread", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0));
    @(negedge clk);
    check("rst_hold_memread", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0));
    rst = 1'b0;
    mflags = 4'h0;
    @(posedge clk);
    #1;
    run(4'h0, 2'b10, 6'b000000, 4'd0, 0, 0, -1);
    run(4'h5, 2'b10, 6'b010000, 4'd0, 0, 0, -1);
    run(4'he, 2'b00, 6'b000101, 4'd6, 0, 0, 4'b1011);
    bus.cond = 4'he;
    bus.op = 2'b00;
    bus.funct = 6'b001000;
    bus.rd = 4'd15;
    step("fetch", mk(1, 1, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b1, -1);
    step("decode", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0), 1'b1, -1);
    step("execr", mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0), 1'b1, -1);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("aluwb_pre_rst", mk(1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0));
    rst = 1'b1;
    #1;
    check("rst_async_aluwb", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    mflags = 4'h0;
    @(posedge clk);
    #1;
    run(4'hd, 2'b10, 6'b000000, 4'd0, 0, 0, -1);
    for (int i = 0; i < 300; i++)
      run(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
